icache_sa: RTL and testbench
============================

ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter ADDR_W, default 32, fetch/memory byte-address width.
REQ-002 Parameter DATA_W, default 32, instruction word width; one word = 4 bytes.
REQ-003 Parameter SETS, default 64, number of sets, power of 2, >=2.
REQ-004 Parameter WAYS, default 2, associativity, one of 1/2/4.
REQ-005 Parameter LINE_WORDS, default 4, words per line, power of 2, >=1.
REQ-006 clk_in  in  1  sole clock, rising edge.
REQ-007 rst_in  in  1  asynchronous, active-high reset.
REQ-008 rdy_in  in  1  global enable; low freezes all state and outputs.
REQ-009 clear  in  1  flush: invalidate all lines, abort refill.
REQ-010 req_valid  in  1  fetch request from IF.
REQ-011 req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-012 req_ready  out  1  request accepted this cycle when req_valid && req_ready.
REQ-013 resp_valid  out  1  one-cycle pulse, response data valid.
REQ-014 resp_data  out  DATA_W  instruction word.
REQ-015 mem_req  out  1  word-read request to memory controller.
REQ-016 mem_addr  out  ADDR_W  word-aligned read address.
REQ-017 mem_valid  in  1  memory word returned.
REQ-018 mem_data  in  DATA_W  returned word.

Function
REQ-019 Address split: offset=[log2(LINE_WORDS)+1:2], index=next log2(SETS) bits, tag=remaining upper bits.
REQ-020 FSM states IDLE, REFILL, RESP; req_ready=1 only in IDLE with clear low and rdy_in high.
REQ-021 Hit (valid way with matching tag in IDLE): resp_valid=1 with the word on the next cycle; FSM stays IDLE; PLRU of set updated.
REQ-022 Miss: IDLE->REFILL; words fetched in order from line base (offset 0) to LINE_WORDS-1.
REQ-023 In REFILL, mem_req=1 with mem_addr=current word address held stable until a cycle with mem_valid=1; next word address driven the following cycle.
REQ-024 On the last mem_valid: line written to the victim way, tag stored, valid set, PLRU updated; REFILL->RESP.
REQ-025 RESP: resp_valid=1 with the requested word for exactly one cycle, then IDLE.
REQ-026 Victim: lowest-index invalid way; if all valid, tree-PLRU victim (WAYS=1: way 0).
REQ-027 clear: all valid bits cleared at that edge; refill aborted without install; FSM->IDLE; no resp_valid; mem_req low next cycle.
REQ-028 mem_valid outside REFILL is ignored.
REQ-029 clear with a simultaneous hit: clear wins, no response.
REQ-030 rdy_in low: no state, counter or PLRU change; outputs hold.

Reset
REQ-031 Asynchronous assertion of rst_in: FSM=IDLE, all valid bits=0, PLRU=0, resp_valid=0, mem_req=0, resp_data=0, mem_addr=0.
REQ-032 Tag/data arrays are not reset.

Configuration
REQ-033 Macro ICACHE_PERF_EN compiled in: adds outputs hit_cnt and miss_cnt (32 bits each), each incremented per accepted hit/miss, wrapping at 2^32, reset to 0, unaffected by clear.
REQ-034 Macro absent: those ports and counters do not exist; behaviour is otherwise identical.

Structure
REQ-035 Shared package holds the FSM state enum, the word-size constant (4 bytes), and width helper constants for offset/index/tag.
REQ-036 One sub-module icache_plru: per-set tree-PLRU storage, victim select, touch update.

Verification
REQ-037 Default parameters, cold fetch 0x100: 4 mem_req reads at 0x100/0x104/0x108/0x10C, resp_valid one cycle after the 4th mem_valid; refetch 0x104 gives a hit next cycle with no mem_req.
REQ-038 WAYS=2: fill 0x000 and 0x400 (same set), touch 0x000, fetch 0x800: evicts 0x400 line; 0x000 still hits.
REQ-039 Miss at 0x200, clear after 2 mem_valid: no resp_valid, mem_req drops; refetch 0x200 refills all 4 words.
REQ-040 mem_valid delayed 5 cycles per word: mem_addr stable throughout; rdy_in low mid-refill stalls without losing progress.
REQ-041 rst_in asserted mid-refill, off-edge: outputs zero immediately; subsequent fetch is a miss.
REQ-042 With ICACHE_PERF_EN: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3; values survive clear.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_sa_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic int offW(input int lineWords);
    return $clog2(lineWords);
  endfunction

  function automatic int idxW(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagW(input int addrW, input int lineWords, input int sets);
    return addrW - BYTE_OFF_W - offW(lineWords) - idxW(sets);
  endfunction

  function automatic int atLeastOne(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  // A 1-way cache still keeps one dummy node so the storage never has zero width.
  function automatic int plruNodes(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU: victim lookup for one set, touch update for another.
module icache_plru
  import icache_sa_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int IDX_W = 6,
  parameter int WAY_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rdSet,
  output logic [WAY_W-1:0] o_victim,
  input  logic             i_touchEn,
  input  logic [IDX_W-1:0] i_touchSet,
  input  logic [WAY_W-1:0] i_touchWay
);

  localparam int NODES = plruNodes(WAYS);

  logic [NODES-1:0] r_tree [SETS];
  logic [2:0]       w_rdBits;
  logic [2:0]       w_oldBits;
  logic [2:0]       w_newBits;
  logic [1:0]       w_way;
  logic [1:0]       w_victim;

  // Each node bit points toward the side holding the victim.
  always_comb begin
    w_rdBits = 3'(r_tree[i_rdSet]);
    w_victim = 2'd0;
    if (WAYS == 4) begin
      w_victim = w_rdBits[0] ? {1'b1, w_rdBits[2]} : {1'b0, w_rdBits[1]};
    end else if (WAYS == 2) begin
      w_victim = {1'b0, w_rdBits[0]};
    end
  end

  assign o_victim = WAY_W'(w_victim);

  // Touching a way turns every node on its path away from it.
  always_comb begin
    w_oldBits = 3'(r_tree[i_touchSet]);
    w_way     = 2'(i_touchWay);
    w_newBits = w_oldBits;
    if (WAYS == 4) begin
      w_newBits[0] = ~w_way[1];
      if (w_way[1]) begin
        w_newBits[2] = ~w_way[0];
      end else begin
        w_newBits[1] = ~w_way[0];
      end
    end else if (WAYS == 2) begin
      w_newBits[0] = ~w_way[0];
    end else begin
      w_newBits = 3'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_tree[s] <= '0;
      end
    end else if (i_touchEn) begin
      r_tree[i_touchSet] <= NODES'(w_newBits);
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative blocking instruction cache with word-by-word line refill.
// Optional hit/miss counters are compiled in with the ICACHE_PERF_EN macro.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W  = offW(LINE_WORDS);
  localparam int OFF_WS = atLeastOne(OFF_W);
  localparam int IDX_W  = idxW(SETS);
  localparam int TAG_W  = tagW(ADDR_W, LINE_WORDS, SETS);
  localparam int WAY_W  = atLeastOne($clog2(WAYS));

  state_t              r_state;
  logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
  logic [DATA_W-1:0]   r_data  [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0]     r_valid [SETS];
  logic [OFF_WS-1:0]   r_reqOff;
  logic [OFF_WS-1:0]   r_wordCnt;
  logic [IDX_W-1:0]    r_reqIdx;
  logic [TAG_W-1:0]    r_reqTag;
  logic [WAY_W-1:0]    r_victim;
  logic                r_respValid;
  logic [DATA_W-1:0]   r_respData;
  logic                r_memReq;
  logic [ADDR_W-1:0]   r_memAddr;

  logic [ADDR_W-1:0]   w_wordAddr;
  logic [OFF_WS-1:0]   w_reqOff;
  logic [IDX_W-1:0]    w_reqIdx;
  logic [TAG_W-1:0]    w_reqTag;
  logic [ADDR_W-1:0]   w_lineBase;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hitWay;
  logic [DATA_W-1:0]   w_hitData;
  logic                w_freeFound;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_plruVictim;
  logic                w_lastWord;
  logic                w_accept;
  logic                w_touchEn;
  logic [IDX_W-1:0]    w_touchSet;
  logic [WAY_W-1:0]    w_touchWay;

  assign w_wordAddr = req_addr >> BYTE_OFF_W;
  assign w_reqOff   = OFF_WS'(w_wordAddr) & OFF_WS'(LINE_WORDS - 1);
  assign w_reqIdx   = IDX_W'(w_wordAddr >> OFF_W);
  assign w_reqTag   = TAG_W'(w_wordAddr >> (OFF_W + IDX_W));
  assign w_lineBase = ADDR_W'({w_reqTag, w_reqIdx}) << (OFF_W + BYTE_OFF_W);

  assign req_ready  = (r_state == ST_IDLE) && !clear && rdy_in;
  assign w_accept   = req_valid && req_ready;
  assign w_lastWord = (r_wordCnt == OFF_WS'(LINE_WORDS - 1));

  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;
  assign mem_req    = r_memReq;
  assign mem_addr   = r_memAddr;

  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_reqIdx][w] && (r_tag[w][w_reqIdx] == w_reqTag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
    end
  end

  assign w_hitData = r_data[w_hitWay][w_reqIdx][w_reqOff];

  // Empty ways are filled lowest-first; PLRU only decides once the set is full.
  always_comb begin
    w_victim    = w_plruVictim;
    w_freeFound = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_freeFound && !r_valid[w_reqIdx][w]) begin
        w_freeFound = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
  end

  assign w_touchEn  = rdy_in && !clear &&
                      (((r_state == ST_IDLE) && req_valid && w_hit) ||
                       ((r_state == ST_REFILL) && mem_valid && w_lastWord));
  assign w_touchSet = (r_state == ST_IDLE) ? w_reqIdx : r_reqIdx;
  assign w_touchWay = (r_state == ST_IDLE) ? w_hitWay : r_victim;

  icache_plru #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_plru (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_rdSet    (w_reqIdx),
    .o_victim   (w_plruVictim),
    .i_touchEn  (w_touchEn),
    .i_touchSet (w_touchSet),
    .i_touchWay (w_touchWay)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_memReq    <= 1'b0;
      r_memAddr   <= '0;
      r_reqOff    <= '0;
      r_reqIdx    <= '0;
      r_reqTag    <= '0;
      r_victim    <= '0;
      r_wordCnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        r_state     <= ST_IDLE;
        r_respValid <= 1'b0;
        r_memReq    <= 1'b0;
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_respValid <= 1'b0;
            if (req_valid) begin
              if (w_hit) begin
                r_respValid <= 1'b1;
                r_respData  <= w_hitData;
              end else begin
                r_state   <= ST_REFILL;
                r_memReq  <= 1'b1;
                r_memAddr <= w_lineBase;
                r_reqOff  <= w_reqOff;
                r_reqIdx  <= w_reqIdx;
                r_reqTag  <= w_reqTag;
                r_victim  <= w_victim;
                r_wordCnt <= '0;
              end
            end
          end
          ST_REFILL: begin
            if (mem_valid) begin
              if (r_wordCnt == r_reqOff) begin
                r_respData <= mem_data;
              end
              if (w_lastWord) begin
                r_memReq                    <= 1'b0;
                r_respValid                 <= 1'b1;
                r_state                     <= ST_RESP;
                r_valid[r_reqIdx][r_victim] <= 1'b1;
              end else begin
                r_wordCnt <= r_wordCnt + OFF_WS'(1);
                r_memAddr <= r_memAddr + ADDR_W'(WORD_BYTES);
              end
            end
          end
          ST_RESP: begin
            r_respValid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Words land in the victim way as they arrive; the valid bit is only set at the end.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear && (r_state == ST_REFILL) && mem_valid) begin
      r_data[r_victim][r_reqIdx][r_wordCnt] <= mem_data;
      if (w_lastWord) begin
        r_tag[r_victim][r_reqIdx] <= r_reqTag;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        r_hitCnt <= r_hitCnt + 32'd1;
      end else begin
        r_missCnt <= r_missCnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hitCnt;
  assign miss_cnt = r_missCnt;
`else
  logic w_acceptUnused;
  assign w_acceptUnused = w_accept;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a simple word-addressed memory responder.
// Define ICACHE_PERF_EN for both DUT and bench to also exercise the counters.
module tb_icache_sa;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int          compared;
  int          mismatched;
  logic [31:0] seenAddr [8];
  int          nServed;
  logic        addrStable;

  icache_sa dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Memory contents are a fixed function of the address so every word is distinct.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic issueFetch(input logic [31:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk_in);
    req_valid = 1'b0;
  endtask

  // Answers mem_req after 'delay' idle cycles per word; records addresses and stability.
  task automatic serveRefill(input int delay, input int maxWords);
    int          waitCnt;
    int          cycles;
    logic [31:0] held;
    nServed    = 0;
    addrStable = 1'b1;
    waitCnt    = 0;
    cycles     = 0;
    held       = '0;
    while (nServed < maxWords && cycles < 200) begin
      if (mem_req) begin
        if (waitCnt == 0) held = mem_addr;
        else if (mem_addr !== held) addrStable = 1'b0;
        if (waitCnt >= delay) begin
          mem_valid = 1'b1;
          mem_data  = memWord(mem_addr);
          seenAddr[nServed] = mem_addr;
          nServed++;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end
      @(negedge clk_in);
      mem_valid = 1'b0;
      mem_data  = '0;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #2 rst_in = 1'b1;
    #1;
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
    compared++; if (resp_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_resp_data: got %h want 0", resp_data); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
    clear = 1'b1;
    #1;
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_blocks_ready: got %b want 0", req_ready); end
    tick();
    clear = 1'b0;
  endtask

  task automatic test_cold_fetch();
    issueFetch(32'h100);
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_mem_req: got %b want 1", mem_req); end
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL cold_ready_in_refill: got %b want 0", req_ready); end
    serveRefill(0, 4);
    compared++; if (nServed !== 4) begin mismatched++; $display("[TB] FAIL cold_words: got %0d want 4", nServed); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (seenAddr[i] !== 32'h100 + 32'(4 * i)) begin mismatched++; $display("[TB] FAIL cold_addr%0d: got %h want %h", i, seenAddr[i], 32'h100 + 32'(4 * i)); end
    end
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_resp_valid: got %b want 1", resp_valid); end
    compared++; if (resp_data !== 32'hC0DE0100) begin mismatched++; $display("[TB] FAIL cold_resp_data: got %h want C0DE0100", resp_data); end
    tick();
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL cold_resp_pulse: got %b want 0", resp_valid); end
    issueFetch(32'h104);
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hit104_valid: got %b want 1", resp_valid); end
    compared++; if (resp_data !== 32'hC0DE0104) begin mismatched++; $display("[TB] FAIL hit104_data: got %h want C0DE0104", resp_data); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL hit104_mem_req: got %b want 0", mem_req); end
    tick();
  endtask

  task automatic test_offset();
    issueFetch(32'h30C);
    serveRefill(0, 4);
    compared++; if (seenAddr[0] !== 32'h300) begin mismatched++; $display("[TB] FAIL offset_base: got %h want 300", seenAddr[0]); end
    compared++; if (resp_data !== 32'hC0DE030C) begin mismatched++; $display("[TB] FAIL offset_resp_data: got %h want C0DE030C", resp_data); end
    tick();
    issueFetch(32'h308);
    compared++; if (resp_data !== 32'hC0DE0308) begin mismatched++; $display("[TB] FAIL offset_hit_data: got %h want C0DE0308", resp_data); end
    tick();
  endtask

  task automatic test_plru();
    issueFetch(32'h000); serveRefill(0, 4); tick();
    issueFetch(32'h400); serveRefill(0, 4); tick();
    issueFetch(32'h000);
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL plru_touch_hit: got %b want 1", resp_valid); end
    tick();
    issueFetch(32'h800);
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL plru_800_miss: got %b want 1", mem_req); end
    serveRefill(0, 4);
    compared++; if (resp_data !== 32'hC0DE0800) begin mismatched++; $display("[TB] FAIL plru_800_data: got %h want C0DE0800", resp_data); end
    tick();
    issueFetch(32'h000);
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL plru_000_kept: got %b want 1", resp_valid); end
    compared++; if (resp_data !== 32'hC0DE0000) begin mismatched++; $display("[TB] FAIL plru_000_data: got %h want C0DE0000", resp_data); end
    tick();
    issueFetch(32'h400);
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL plru_400_evicted: got %b want 1", mem_req); end
    serveRefill(0, 4);
    tick();
  endtask

  task automatic test_clear();
    int respSeen;
    int memReqSeen;
    issueFetch(32'h200);
    serveRefill(0, 2);
    compared++; if (mem_addr !== 32'h208) begin mismatched++; $display("[TB] FAIL clear_pre_addr: got %h want 208", mem_addr); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_mem_req: got %b want 0", mem_req); end
    respSeen = 0;
    memReqSeen = 0;
    mem_valid = 1'b1;
    mem_data  = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid === 1'b1) respSeen++;
      if (mem_req === 1'b1) memReqSeen++;
      tick();
    end
    mem_valid = 1'b0;
    compared++; if (respSeen !== 0) begin mismatched++; $display("[TB] FAIL clear_no_resp: got %0d pulses want 0", respSeen); end
    compared++; if (memReqSeen !== 0) begin mismatched++; $display("[TB] FAIL clear_idle_mem_req: got %0d cycles want 0", memReqSeen); end
    issueFetch(32'h200);
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_refetch_miss: got %b want 1", mem_req); end
    serveRefill(0, 4);
    compared++; if (seenAddr[0] !== 32'h200) begin mismatched++; $display("[TB] FAIL clear_refill_first: got %h want 200", seenAddr[0]); end
    compared++; if (seenAddr[3] !== 32'h20C) begin mismatched++; $display("[TB] FAIL clear_refill_last: got %h want 20C", seenAddr[3]); end
    compared++; if (resp_data !== 32'hC0DE0200) begin mismatched++; $display("[TB] FAIL clear_refill_data: got %h want C0DE0200", resp_data); end
    tick();
    clear     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h200;
    tick();
    clear     = 1'b0;
    req_valid = 1'b0;
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_beats_hit: got %b want 0", resp_valid); end
    issueFetch(32'h104);
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_flushed_104: got %b want 1", mem_req); end
    serveRefill(0, 4);
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h100 + 32'(4 * i);
      tick();
      compared++; if (resp_valid !== 1'b1 || resp_data !== memWord(32'h100 + 32'(4 * i))) begin
        mismatched++; $display("[TB] FAIL b2b_hit%0d: got %b/%h want 1/%h", i, resp_valid, resp_data, memWord(32'h100 + 32'(4 * i)));
      end
    end
    req_valid = 1'b0;
    tick();
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle: got %b want 0", resp_valid); end
  endtask

  task automatic test_slow_mem();
    issueFetch(32'h500);
    serveRefill(5, 4);
    compared++; if (addrStable !== 1'b1) begin mismatched++; $display("[TB] FAIL slow_addr_stable: got %b want 1", addrStable); end
    compared++; if (nServed !== 4 || seenAddr[3] !== 32'h50C) begin mismatched++; $display("[TB] FAIL slow_words: got %0d/%h want 4/50C", nServed, seenAddr[3]); end
    compared++; if (resp_valid !== 1'b1 || resp_data !== 32'hC0DE0500) begin mismatched++; $display("[TB] FAIL slow_resp: got %b/%h want 1/C0DE0500", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_stall();
    issueFetch(32'h60C);
    serveRefill(0, 2);
    rdy_in    = 1'b0;
    mem_valid = 1'b1;
    mem_data  = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h608) begin mismatched++; $display("[TB] FAIL stall_hold%0d: got %b/%h want 1/608", i, mem_req, mem_addr); end
    end
    rdy_in    = 1'b1;
    mem_valid = 1'b0;
    serveRefill(0, 2);
    compared++; if (seenAddr[0] !== 32'h608 || seenAddr[1] !== 32'h60C) begin mismatched++; $display("[TB] FAIL stall_resume: got %h/%h want 608/60C", seenAddr[0], seenAddr[1]); end
    compared++; if (resp_valid !== 1'b1 || resp_data !== 32'hC0DE060C) begin mismatched++; $display("[TB] FAIL stall_resp: got %b/%h want 1/C0DE060C", resp_valid, resp_data); end
    tick();
    issueFetch(32'h608);
    compared++; if (resp_data !== 32'hC0DE0608) begin mismatched++; $display("[TB] FAIL stall_hit_data: got %h want C0DE0608", resp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    issueFetch(32'h700);
    serveRefill(0, 1);
    #2 rst_in = 1'b1;
    #1;
    compared++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_mem: got %b/%h want 0/0", mem_req, mem_addr); end
    compared++; if (resp_data !== 32'h0 || resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_resp: got %b/%h want 0/0", resp_valid, resp_data); end
    tick();
    rst_in = 1'b0;
    issueFetch(32'h100);
    compared++; if (mem_req !== 1'b1 || resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_miss: got req %b resp %b want 1/0", mem_req, resp_valid); end
    serveRefill(0, 4);
    compared++; if (resp_data !== 32'hC0DE0100) begin mismatched++; $display("[TB] FAIL rstmid_refill: got %h want C0DE0100", resp_data); end
    tick();
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    #2 rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    issueFetch(32'h000); serveRefill(0, 4); tick();
    issueFetch(32'h000); issueFetch(32'h004); issueFetch(32'h008);
    tick();
    compared++; if (miss_cnt !== 32'd1) begin mismatched++; $display("[TB] FAIL perf_miss: got %0d want 1", miss_cnt); end
    compared++; if (hit_cnt !== 32'd3) begin mismatched++; $display("[TB] FAIL perf_hit: got %0d want 3", hit_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd3) begin mismatched++; $display("[TB] FAIL perf_after_clear: got %0d/%0d want 1/3", miss_cnt, hit_cnt); end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_in     = 1'b0;
    rdy_in     = 1'b1;
    clear      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    mem_valid  = 1'b0;
    mem_data   = '0;
    test_reset();
    test_cold_fetch();
    test_offset();
    test_plru();
    test_clear();
    test_back_to_back();
    test_slow_mem();
    test_stall();
    test_reset_mid();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
